// File: rtl/pulse_stretcher.sv
// Stretches one-cycle requests into HOLD_CYCLES-long high pulses, each followed by GAP_CYCLES forced low.
// Optional macro PULSE_STRETCHER_QUEUE_EN: queue up to 7 requests that arrive while busy.
module pulse_stretcher #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       P_in,
    output logic       L_out,
    output logic       busy,
    output logic [2:0] pending,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_e;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        lout_q;
    logic        busy_q;
    logic        ovf_q;

`ifdef PULSE_STRETCHER_QUEUE_EN
    logic [2:0]  pend_q;

    // A full queue drops the request, even on the edge that starts a queued hold.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lout_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (P_in) begin
                        state_q <= HOLD;
                        lout_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= GAP;
                        lout_q  <= 1'b0;
                        cnt_q   <= GAP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                    if (P_in) begin
                        if (pend_q != 3'd7) pend_q <= pend_q + 3'd1;
                        else                ovf_q  <= 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 16'd1;
                        if (P_in) begin
                            if (pend_q != 3'd7) pend_q <= pend_q + 3'd1;
                            else                ovf_q  <= 1'b1;
                        end
                    end else if (pend_q != '0) begin
                        state_q <= HOLD;
                        lout_q  <= 1'b1;
                        cnt_q   <= HOLD_LOAD;
                        if (P_in && pend_q != 3'd7) begin
                            pend_q <= pend_q;
                        end else begin
                            pend_q <= pend_q - 3'd1;
                            if (P_in) ovf_q <= 1'b1;
                        end
                    end else if (P_in) begin
                        state_q <= HOLD;
                        lout_q  <= 1'b1;
                        cnt_q   <= HOLD_LOAD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    lout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pending = pend_q;
`else
    // Without the queue every request seen while busy is dropped, except one on the final gap edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lout_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (P_in) begin
                        state_q <= HOLD;
                        lout_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= GAP;
                        lout_q  <= 1'b0;
                        cnt_q   <= GAP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                    if (P_in) ovf_q <= 1'b1;
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 16'd1;
                        if (P_in) ovf_q <= 1'b1;
                    end else if (P_in) begin
                        state_q <= HOLD;
                        lout_q  <= 1'b1;
                        cnt_q   <= HOLD_LOAD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    lout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pending = 3'd0;
`endif

    assign L_out    = lout_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomised and directed bench for pulse_stretcher; the model keeps a list of scheduled hold start edges.
module tb_pulse_stretcher;

    localparam int H = 10;
    localparam int G = 2;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       P_in   = 1'b0;
    logic       L_out;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    int   checks = 0;
    int   errors = 0;
    int   edgeNo = 0;
    int   starts[$];
    logic modelOvf = 1'b0;

    pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .P_in     (P_in),
        .L_out    (L_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk_in = ~clk_in;

    // Each hold starts at an edge s: high after edges s..s+H-1, busy through s+H+G-1.
    function automatic logic expL();
        for (int i = 0; i < starts.size(); i++)
            if (edgeNo >= starts[i] && edgeNo <= starts[i] + H - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic expBusy();
        for (int i = 0; i < starts.size(); i++)
            if (edgeNo >= starts[i] && edgeNo <= starts[i] + H + G - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] expPending();
        int n;
        n = 0;
        for (int i = 0; i < starts.size(); i++)
            if (starts[i] > edgeNo) n++;
        return 3'(n);
    endfunction

    // Drive one edge, update the schedule, and return at the following falling edge.
    task automatic tick(input logic p, input logic r);
        int t;
        int endT;
        int pend;
        P_in  = p;
        reset = r;
        @(posedge clk_in);
        edgeNo++;
        t = edgeNo;
        if (r) begin
            starts.delete();
            modelOvf = 1'b0;
        end else if (p) begin
            endT = (starts.size() == 0) ? -1 : starts[$] + H + G;
            if (starts.size() == 0 || t >= endT) begin
                starts.push_back(t);
            end else begin
`ifdef PULSE_STRETCHER_QUEUE_EN
                pend = 0;
                for (int i = 0; i < starts.size(); i++)
                    if (starts[i] >= t) pend++;
                if (pend < 7) starts.push_back(endT);
                else          modelOvf = 1'b1;
`else
                pend = 0;
                modelOvf = 1'b1;
`endif
            end
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        checks++; if (L_out !== 1'b0)    begin errors++; $display("[TB] FAIL reset.L got %b want 0", L_out); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset.busy got %b want 0", busy); end
        checks++; if (pending !== 3'd0)  begin errors++; $display("[TB] FAIL reset.pending got %0d want 0", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset.overflow got %b want 0", overflow); end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_single();
        int s;
        int rel;
        tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        s = edgeNo;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick(1'b0, 1'b0);
            rel = edgeNo - s;
            checks++; if (L_out !== (rel <= H - 1))
                begin errors++; $display("[TB] FAIL single.L rel=%0d got %b want %b", rel, L_out, rel <= H - 1); end
            checks++; if (busy !== (rel <= H + G - 1))
                begin errors++; $display("[TB] FAIL single.busy rel=%0d got %b want %b", rel, busy, rel <= H + G - 1); end
            checks++; if (pending !== 3'd0 || overflow !== 1'b0)
                begin errors++; $display("[TB] FAIL single.flags rel=%0d got pending=%0d ovf=%b want 0/0", rel, pending, overflow); end
        end
    endtask

    task automatic test_queue();
        int s;
        int rel;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        s = edgeNo;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
`ifdef PULSE_STRETCHER_QUEUE_EN
        checks++; if (pending !== 3'd2) begin errors++; $display("[TB] FAIL queue.pending2 got %0d want 2", pending); end
`else
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL queue.dropOvf got %b want 1", overflow); end
`endif
        for (int k = 0; k < 40; k++) begin
            tick(1'b0, 1'b0);
            rel = edgeNo - s;
            checks++; if (L_out !== expL())
                begin errors++; $display("[TB] FAIL queue.L rel=%0d got %b want %b", rel, L_out, expL()); end
            checks++; if (busy !== expBusy())
                begin errors++; $display("[TB] FAIL queue.busy rel=%0d got %b want %b", rel, busy, expBusy()); end
            checks++; if (pending !== expPending())
                begin errors++; $display("[TB] FAIL queue.pending rel=%0d got %0d want %0d", rel, pending, expPending()); end
`ifdef PULSE_STRETCHER_QUEUE_EN
            if (rel == 2 * (H + G)) begin
                checks++; if (L_out !== 1'b1 || pending !== 3'd0)
                    begin errors++; $display("[TB] FAIL queue.third rel=%0d got L=%b pending=%0d want 1/0", rel, L_out, pending); end
            end
`endif
        end
    endtask

    task automatic test_overflow();
        int holds;
        logic prevL;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        holds = 0;
        prevL = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick(1'b1, 1'b0);
            if (L_out && !prevL) holds++;
            prevL = L_out;
`ifdef PULSE_STRETCHER_QUEUE_EN
            if (k == 7) begin
                checks++; if (pending !== 3'd7 || overflow !== 1'b0)
                    begin errors++; $display("[TB] FAIL ovf.full got pending=%0d ovf=%b want 7/0", pending, overflow); end
            end
`endif
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf.set got %b want 1", overflow); end
        for (int k = 0; k < 110; k++) begin
            tick(1'b0, 1'b0);
            if (L_out && !prevL) holds++;
            prevL = L_out;
        end
`ifdef PULSE_STRETCHER_QUEUE_EN
        checks++; if (holds !== 8) begin errors++; $display("[TB] FAIL ovf.holds got %0d want 8", holds); end
`else
        checks++; if (holds !== 1) begin errors++; $display("[TB] FAIL ovf.holds got %0d want 1", holds); end
`endif
        checks++; if (overflow !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("[TB] FAIL ovf.sticky got ovf=%b busy=%b want 1/0", overflow, busy); end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
`ifdef PULSE_STRETCHER_QUEUE_EN
        tick(1'b1, 1'b0);
        repeat (H + G - 2) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++; if (L_out !== 1'b1 || pending !== 3'd1)
            begin errors++; $display("[TB] FAIL b2b.simul got L=%b pending=%0d want 1/1", L_out, pending); end
`else
        repeat (H + G - 1) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++; if (L_out !== 1'b1 || pending !== 3'd0 || overflow !== 1'b0)
            begin errors++; $display("[TB] FAIL b2b.reenter got L=%b pending=%0d ovf=%b want 1/0/0", L_out, pending, overflow); end
`endif
        repeat (30) begin
            tick(1'b0, 1'b0);
            checks++; if (L_out !== expL() || pending !== expPending())
                begin errors++; $display("[TB] FAIL b2b.track e=%0d got L=%b p=%0d want %b/%0d", edgeNo, L_out, pending, expL(), expPending()); end
        end
    endtask

    task automatic test_reset_mid();
        int s;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        checks++; if (L_out !== 1'b0 || busy !== 1'b0 || pending !== 3'd0 || overflow !== 1'b0)
            begin errors++; $display("[TB] FAIL rstmid.clear got L=%b busy=%b p=%0d ovf=%b want 0", L_out, busy, pending, overflow); end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        s = edgeNo;
        repeat (H) tick(1'b0, 1'b0);
        checks++; if (L_out !== 1'b0 || busy !== 1'b1 || pending !== 3'd0)
            begin errors++; $display("[TB] FAIL rstmid.clean got L=%b busy=%b p=%0d at rel %0d want 0/1/0", L_out, busy, pending, edgeNo - s); end
        tick(1'b1, 1'b1);
        checks++; if (busy !== 1'b0 || L_out !== 1'b0)
            begin errors++; $display("[TB] FAIL rstmid.priority got busy=%b L=%b want 0/0", busy, L_out); end
    endtask

    task automatic test_random();
        logic p;
        logic r;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 399) == 0);
            if (k < 1500) p = ($urandom_range(0, 1) == 0);
            else          p = ($urandom_range(0, 9) == 0);
            tick(p, r);
            checks++; if (L_out !== expL())
                begin errors++; $display("[TB] FAIL rand.L e=%0d got %b want %b", edgeNo, L_out, expL()); end
            checks++; if (busy !== expBusy())
                begin errors++; $display("[TB] FAIL rand.busy e=%0d got %b want %b", edgeNo, busy, expBusy()); end
            checks++; if (pending !== expPending())
                begin errors++; $display("[TB] FAIL rand.pending e=%0d got %0d want %0d", edgeNo, pending, expPending()); end
            checks++; if (overflow !== modelOvf)
                begin errors++; $display("[TB] FAIL rand.overflow e=%0d got %b want %b", edgeNo, overflow, modelOvf); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter HOLD_CYCLES, default 10, number of cycles L_out stays high per request; legal range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 2, number of forced-low cycles after each hold; legal range 1..65535.
REQ-003 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 P_in  input  1  request input; each cycle it is sampled high is one request (normally a one-shot from the debouncer).
REQ-006 L_out  output  1  stretched level output, registered.
REQ-007 busy  output  1  high whenever the state is not IDLE, registered.
REQ-008 pending  output  3  count of queued, not-yet-started requests, 0..7.
REQ-009 overflow  output  1  sticky flag, set when a request is dropped.

Function
REQ-010 The FSM SHALL have three states: IDLE, HOLD and GAP.
REQ-011 Counting SHALL use one 16-bit down-counter shared by HOLD and GAP.
REQ-012 In IDLE, P_in sampled high SHALL cause the following transitions at that edge:
  - move to HOLD
  - set L_out=1
  - load the counter with HOLD_CYCLES-1
REQ-013 Latency SHALL be exactly one cycle, from the edge that samples P_in to L_out high.
REQ-014 L_out SHALL stay high for exactly HOLD_CYCLES cycles.
REQ-015 When the HOLD counter reaches 0, the next edge SHALL:
  - move to GAP
  - set L_out=0
  - load the counter with GAP_CYCLES-1
REQ-016 L_out SHALL stay low in GAP for exactly GAP_CYCLES cycles.
REQ-017 When the GAP counter reaches 0 with pending>0, the next edge SHALL:
  - move to HOLD
  - set L_out=1
  - decrement pending
REQ-018 When the GAP counter reaches 0 with pending=0, the next edge SHALL move to IDLE.
REQ-019 busy SHALL equal (state != IDLE) and SHALL update on the same edge as the state change.
REQ-020 P_in high while in HOLD or GAP SHALL be handled as set by REQ-030/REQ-031.
REQ-021 Queuing a request and starting a queued request at the same edge SHALL leave pending unchanged.
REQ-022 P_in high at the last GAP edge with pending=0 SHALL re-enter HOLD directly, with pending still 0.
REQ-023 pending SHALL saturate at 7; a request arriving at pending=7 SHALL be dropped and SHALL set overflow.
REQ-024 overflow SHALL clear only on reset.
REQ-025 A gap of at least GAP_CYCLES low cycles SHALL always separate two consecutive holds.

Reset
REQ-026 On reset, the next edge SHALL set:
  - state=IDLE
  - L_out=0
  - busy=0
  - pending=0
  - overflow=0
  - counter=0
REQ-027 Reset SHALL take priority over P_in in the same cycle.
REQ-028 Reset mid-HOLD or mid-GAP SHALL abort the operation and discard queued requests.
REQ-029 There SHALL be no asynchronous reset path.

Configuration
REQ-030 With macro PULSE_STRETCHER_QUEUE_EN defined, requests arriving in HOLD or GAP SHALL be queued as in REQ-017, REQ-021 and REQ-023.
REQ-031 With PULSE_STRETCHER_QUEUE_EN undefined, the queue is removed:
  - pending SHALL be tied to 0
  - any request in HOLD or GAP SHALL be dropped and SHALL set overflow
  - REQ-022 still applies

Verification (defaults HOLD_CYCLES=10, GAP_CYCLES=2; cycle n = edge n)
REQ-032 Single request: P_in high at 5 -> L_out high 6..15, low from 16; busy high 6..17, low from 18; pending=0; overflow=0.
REQ-033 Queue: P_in high at 5,6,7 with QUEUE_EN -> pending=2 after 7; L_out high 6..15, 18..27, 30..39; pending=1 at 18, 0 at 30; busy low from 42.
REQ-034 Overflow: P_in high 5..13 with QUEUE_EN -> pending=7 after 12; overflow=1 after 13; eight holds total; overflow stays 1 until reset.
REQ-035 Simultaneous: pending=1, P_in high on the last GAP cycle -> new HOLD starts next cycle with pending still 1.
REQ-036 Reset mid-op: reset at 9 during HOLD with pending=3 -> at 10 L_out=0, busy=0, pending=0, overflow=0; a P_in at 12 starts a clean hold 13..22.
REQ-037 No queue: QUEUE_EN undefined, P_in at 5 and 8 -> one hold 6..15; overflow=1 after 8; pending always 0.
